nes_pad_emulator: RTL and testbench

- Emulates one NES standard joypad (4021 shift register behaviour) from eight board push-buttons.
- Sits directly downstream of the controller interface. It consumes that block's latch output and one per-port clock output, and drives the matching controller data input.
- Inputs are synchronised and debounced, the opposing-direction filter is applied, and the result is presented as an active-low serial stream, exactly as a physical pad drives the line.

---
 rtl/nes_pad_emulator.sv | 200 ++++++++++++++++++++
 tb/tb_nes_pad_emulator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_emulator.sv
// nes_pad_emulator
//   Emulates one NES standard joypad (4021-style parallel-in/serial-out) from
//   eight board push-buttons.  Buttons are synchronised, debounced on a slow
//   sample tick, passed through the opposing-direction filter and presented
//   on an active-low serial line driven by the controller interface's latch
//   and per-port clock.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_raw    [7:0] raw buttons, 1 = pressed
//              (0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right)
//   pad_latch  parallel-load strobe, synchronous to clk
//   pad_clk    read clock, idles high, low while the CPU samples a bit
//   pad_data   serial line, 0 = current bit pressed
//   btn_state  [7:0] debounced, filtered buttons, 1 = pressed

// Per-button debouncer: the state bit only follows the synchronised input
// after STABLE_SAMPLES consecutive ticks that all disagree with it.
module nes_pad_debounce #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  output logic db_out
);

  logic [3:0] cnt_q, cnt_d;
  logic       db_q, db_d;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick) begin
      if (sync_in != db_q) begin
        if (cnt_q + 4'd1 == 4'(STABLE_SAMPLES)) begin
          db_d  = sync_in;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        // any agreeing sample restarts the run
        cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_out = db_q;

endmodule

module nes_pad_emulator #(
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 4,
  parameter int BLOCK_OPPOSING = 1,
  parameter int FILL_LEVEL     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_raw,
  input  logic       pad_latch,
  input  logic       pad_clk,
  output logic       pad_data,
  output logic [7:0] btn_state
);

  localparam int NUM_BTN = 8;
  localparam int TW      = $clog2(TICK_DIV);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous buttons
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce sample tick: one-cycle pulse every TICK_DIV clocks
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Per-button debouncers
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] db;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
    nes_pad_debounce #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (sync2_q[b]),
      .db_out  (db[b])
    );
  end

  // ---------------------------------------------------------------------------
  // Opposing-direction filter, registered for the debug/LED output
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_state_q, btn_state_d;

  always_comb begin
    btn_state_d = db;
    if (BLOCK_OPPOSING != 0) begin
      if (db[4] && db[5]) btn_state_d[5:4] = 2'b00;  // Up + Down
      if (db[6] && db[7]) btn_state_d[7:6] = 2'b00;  // Left + Right
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_state_q <= '0;
    else     btn_state_q <= btn_state_d;
  end

  assign btn_state = btn_state_q;

  // ---------------------------------------------------------------------------
  // 4021-style shift register holding line levels (0 = pressed).
  // The load is level-sensitive so buttons stay live while the latch is high,
  // and shifting happens on pad_clk returning high so the low phase presents
  // the current bit.
  // ---------------------------------------------------------------------------
  logic               pad_clk_q, pad_clk_d;
  logic               pad_latch_q, pad_latch_d;
  logic [NUM_BTN-1:0] sreg_q, sreg_d;
  logic               clk_rise;

  assign clk_rise = pad_clk & ~pad_clk_q;

  always_comb begin
    pad_clk_d   = pad_clk;
    pad_latch_d = pad_latch;
    sreg_d      = sreg_q;
    if (pad_latch) begin
      sreg_d = ~btn_state_q;
    end else if (clk_rise) begin
      sreg_d = {1'(FILL_LEVEL), sreg_q[NUM_BTN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_clk_q   <= 1'b1;
      pad_latch_q <= 1'b0;
      sreg_q      <= '1;
    end else begin
      pad_clk_q   <= pad_clk_d;
      pad_latch_q <= pad_latch_d;
      sreg_q      <= sreg_d;
    end
  end

  assign pad_data = sreg_q[0];

  // pad_latch_q is kept as a delayed copy of the strobe for debug probing.
  logic unused_ok;
  assign unused_ok = pad_latch_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// tb_nes_pad_emulator
//   Two instances share all inputs: u_dut (opposing filter on, fill 0) and
//   u_dut_nb (filter off, fill 1).  A table of button patterns is debounced,
//   read out as a full frame and compared with hand-derived constants; a few
//   hand-written sequences cover latch priority, glitch rejection and reset
//   mid-frame; a random phase is checked every cycle against a behavioural
//   model that tracks each frame as a captured vector plus a read index.
module tb_nes_pad_emulator;

  localparam int TD = 4;
  localparam int SS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_raw;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data0, pad_data1;
  logic [7:0] btn_state0, btn_state1;

  always #5 clk = ~clk;

  nes_pad_emulator #(
    .TICK_DIV(TD), .STABLE_SAMPLES(SS), .BLOCK_OPPOSING(1), .FILL_LEVEL(0)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .pad_data(pad_data0), .btn_state(btn_state0)
  );

  nes_pad_emulator #(
    .TICK_DIV(TD), .STABLE_SAMPLES(SS), .BLOCK_OPPOSING(0), .FILL_LEVEL(1)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .pad_data(pad_data1), .btn_state(btn_state1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int unsigned m_cyc;
  logic [7:0]  m_hist [2];     // raw samples seen 1 and 2 edges ago
  logic [7:0]  m_db;
  int          m_run [8];      // consecutive disagreeing ticks per button
  logic [7:0]  m_bs [2];
  logic [7:0]  m_frame [2];    // captured line levels of the current frame
  int          m_idx [2];      // number of reads completed
  logic        m_pclk_prev;

  function automatic logic [7:0] filt(input logic [7:0] v, input bit block);
    logic [7:0] r;
    r = v;
    if (block) begin
      if (v[4] && v[5]) r = r & 8'hCF;
      if (v[6] && v[7]) r = r & 8'h3F;
    end
    return r;
  endfunction

  function automatic logic exp_pad(input int i);
    if (m_idx[i] >= 8) return (i == 0) ? 1'b0 : 1'b1;
    return m_frame[i][m_idx[i]];
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_hist[0] = '0; m_hist[1] = '0;
    m_db = '0;
    for (int b = 0; b < 8; b++) m_run[b] = 0;
    for (int i = 0; i < 2; i++) begin
      m_bs[i] = '0; m_frame[i] = 8'hFF; m_idx[i] = 0;
    end
    m_pclk_prev = 1'b1;
  endtask

  task automatic model_step();
    bit         tick;
    logic [7:0] db_old, bs_old, smp;
    tick   = (m_cyc % TD) == TD - 1;
    m_cyc++;
    smp    = m_hist[1];
    db_old = m_db;
    if (tick) begin
      for (int b = 0; b < 8; b++) begin
        if (smp[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == SS) begin m_db[b] = smp[b]; m_run[b] = 0; end
        end else m_run[b] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      bs_old  = m_bs[i];
      m_bs[i] = filt(db_old, i == 0);
      if (pad_latch) begin
        m_frame[i] = ~bs_old;
        m_idx[i]   = 0;
      end else if (pad_clk && !m_pclk_prev && m_idx[i] < 9) begin
        m_idx[i]++;
      end
    end
    m_pclk_prev = pad_clk;
    m_hist[1] = m_hist[0];
    m_hist[0] = btn_raw;
  endtask

  always begin
    @(posedge clk);
    if (!rst) model_step();
  end

  // every-cycle comparison against the model
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("mdl_pad0",   {9'b0, pad_data0}, {9'b0, exp_pad(0)});
      chk("mdl_pad1",   {9'b0, pad_data1}, {9'b0, exp_pad(1)});
      chk("mdl_state0", {2'b0, btn_state0}, {2'b0, m_bs[0]});
      chk("mdl_state1", {2'b0, btn_state1}, {2'b0, m_bs[1]});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // latch pulse then 10 reads; bit k of d holds the level seen on read k
  task automatic read_frame(output logic [9:0] d0, output logic [9:0] d1);
    @(negedge clk); pad_latch = 1'b1;
    @(negedge clk); pad_latch = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pad_clk = 1'b0;
      @(negedge clk);
      d0[k] = pad_data0;
      d1[k] = pad_data1;
      pad_clk = 1'b1;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] raw;
    logic [7:0] st0;   // filter on
    logic [7:0] st1;   // filter off
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [9:0] r0, r1;
    int         n;
    int         hold;

    tbl[0] = '{raw: 8'h00, st0: 8'h00, st1: 8'h00};
    tbl[1] = '{raw: 8'h09, st0: 8'h09, st1: 8'h09};
    tbl[2] = '{raw: 8'h70, st0: 8'h40, st1: 8'h70};
    tbl[3] = '{raw: 8'h30, st0: 8'h00, st1: 8'h30};
    tbl[4] = '{raw: 8'hC5, st0: 8'h05, st1: 8'hC5};
    tbl[5] = '{raw: 8'hFF, st0: 8'h0F, st1: 8'hFF};

    rst = 1'b1; btn_raw = '0; pad_latch = 1'b0; pad_clk = 1'b1;
    model_reset();
    cycles(3);
    chk("rst_pad0",   {9'b0, pad_data0}, 10'h001);
    chk("rst_state0", {2'b0, btn_state0}, 10'h000);
    rst = 1'b0;
    chk_en = 1'b1;
    cycles(2);

    // table: debounce a pattern, then read a whole frame
    for (int t = 0; t < 6; t++) begin
      btn_raw = tbl[t].raw;
      cycles(30);
      chk($sformatf("tbl%0d_state0", t), {2'b0, btn_state0}, {2'b0, tbl[t].st0});
      chk($sformatf("tbl%0d_state1", t), {2'b0, btn_state1}, {2'b0, tbl[t].st1});
      read_frame(r0, r1);
      chk($sformatf("tbl%0d_reads0", t), r0, {2'b00, ~tbl[t].st0});
      chk($sformatf("tbl%0d_reads1", t), r1, {2'b11, ~tbl[t].st1});
    end

    // glitch shorter than the debounce window is rejected
    btn_raw = 8'h00;
    cycles(30);
    for (int g = 0; g < 20; g++) begin
      btn_raw[1] = ~btn_raw[1];
      cycles(3);
      chk("glitch_b", {9'b0, btn_state0[1]}, 10'h000);
    end
    btn_raw = 8'h00;
    cycles(20);
    btn_raw = 8'h02;
    n = 0;
    while (n < 40 && !btn_state0[1]) begin
      @(negedge clk);
      n++;
    end
    chk("stable_latency_ok", {9'b0, (n >= 12 && n <= 15)}, 10'h001);

    // latch high wins over pad_clk rises; value held after latch falls
    btn_raw = 8'h01;
    cycles(30);
    pad_latch = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pad_clk = 1'b0; @(negedge clk);
      chk("latch_hi_lo", {9'b0, pad_data0}, 10'h000);
      pad_clk = 1'b1; @(negedge clk);
      chk("latch_hi_hi", {9'b0, pad_data0}, 10'h000);
    end
    pad_latch = 1'b0; @(negedge clk);
    chk("latch_held", {9'b0, pad_data0}, 10'h000);
    pad_clk = 1'b0; @(negedge clk);
    chk("latch_read_a", {9'b0, pad_data0}, 10'h000);
    pad_clk = 1'b1; @(negedge clk);
    chk("latch_read_b", {9'b0, pad_data0}, 10'h001);

    // reset in the middle of a frame
    btn_raw = 8'h0F;
    cycles(30);
    @(negedge clk); pad_latch = 1'b1;
    @(negedge clk); pad_latch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pad_clk = 1'b0; @(negedge clk);
      pad_clk = 1'b1; @(negedge clk);
    end
    pad_clk = 1'b0; @(negedge clk);
    chk("mid_before_rst", {9'b0, pad_data0}, 10'h000);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_pad0", {9'b0, pad_data0}, 10'h001);
    chk("mid_rst_pad1", {9'b0, pad_data1}, 10'h001);
    chk("mid_rst_state", {2'b0, btn_state0}, 10'h000);
    @(negedge clk);
    rst = 1'b0; pad_clk = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pad_clk = 1'b0; @(negedge clk);
      chk("post_rst_read", {9'b0, pad_data0}, 10'h001);
      pad_clk = 1'b1; @(negedge clk);
    end
    cycles(30);
    @(negedge clk); pad_latch = 1'b1;
    @(negedge clk); pad_latch = 1'b0;
    chk("relatch_pad0", {9'b0, pad_data0}, 10'h000);

    // random phase, checked every cycle by the model
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        case ($urandom_range(0, 2))
          0:       btn_raw = 8'($urandom);
          1:       btn_raw = btn_raw ^ 8'(1 << $urandom_range(0, 7));
          default: btn_raw = 8'hF0 | 8'($urandom_range(0, 15));
        endcase
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      pad_latch = ($urandom_range(0, 15) == 0);
      pad_clk   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
